pattern_history_table: RTL and testbench

//  Second level of the two-level branch predictor. Consumes the per-branch

---
 rtl/bp_pkg.sv | 33 +++
 rtl/sat_stat_counter.sv | 23 ++
 rtl/pattern_history_table.sv | 89 ++++++++
 tb/tb_pattern_history_table.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the two-level branch predictor (history tracker and PHT).
package bp_pkg;

  localparam int unsigned IWIDTH_DEF = 6;
  localparam int unsigned HWIDTH_DEF = 4;
  localparam int unsigned CWIDTH_DEF = 2;

  // Widest counter the helpers support; callers truncate to their own CWIDTH.
  localparam int unsigned CMAX = 16;

  typedef logic [CMAX-1:0] cnt_max_t;
  typedef logic [IWIDTH_DEF+HWIDTH_DEF-1:0] pidx_t;

  function automatic cnt_max_t weak_nt(int unsigned cw);
    return (cnt_max_t'(1) << (cw - 1)) - cnt_max_t'(1);
  endfunction

  function automatic cnt_max_t strong_t(int unsigned cw);
    return (cnt_max_t'(1) << cw) - cnt_max_t'(1);
  endfunction

  localparam cnt_max_t WEAK_NT  = weak_nt(CWIDTH_DEF);
  localparam cnt_max_t STRONG_T = strong_t(CWIDTH_DEF);

  // Saturating step towards the resolved direction.
  function automatic cnt_max_t sat_next(cnt_max_t cnt, int unsigned cw, logic dir);
    if (dir) begin
      return (cnt >= strong_t(cw)) ? cnt : cnt + cnt_max_t'(1);
    end
    return (cnt == '0) ? cnt : cnt - cnt_max_t'(1);
  endfunction

endpackage

// File: rtl/sat_stat_counter.sv
// Event counter that clamps at all-ones instead of wrapping.
module sat_stat_counter #(
  parameter int unsigned SWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [SWIDTH-1:0] count
);

  logic [SWIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_history_table.sv
// Second-level predictor table: {index, history} selects a saturating counter whose MSB
// predicts; the previous lookup is trained on resolve, with same-cycle bypass.
module pattern_history_table
  import bp_pkg::*;
#(
  parameter int unsigned IWIDTH = IWIDTH_DEF,
  parameter int unsigned HWIDTH = HWIDTH_DEF,
  parameter int unsigned CWIDTH = CWIDTH_DEF,
  parameter int unsigned SWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              do_update,
  input  logic              last_taken,
  input  logic [IWIDTH-1:0] index,
  input  logic [HWIDTH-1:0] history,
  output logic              taken,
  output logic [CWIDTH-1:0] counter,
  output logic [SWIDTH-1:0] update_cnt,
  output logic [SWIDTH-1:0] mispred_cnt
);

  localparam int unsigned PW    = IWIDTH + HWIDTH;
  localparam int unsigned DEPTH = 1 << PW;
  localparam logic [CWIDTH-1:0] WEAK = CWIDTH'(weak_nt(CWIDTH));

  logic [PW-1:0]     pidx;
  logic [PW-1:0]     last_pidx_q;
  logic              last_pred_q;
  logic [CWIDTH-1:0] tbl_q [DEPTH];
  logic [CWIDTH-1:0] old_cnt;
  logic [CWIDTH-1:0] train_cnt;
  logic              upd;
  logic              mispred;

  assign pidx      = {index, history};
  assign upd       = en & do_update;
  assign old_cnt   = tbl_q[last_pidx_q];
  assign train_cnt = CWIDTH'(sat_next(cnt_max_t'(old_cnt), CWIDTH, last_taken));
  assign mispred   = upd & (last_pred_q != last_taken);

  // Reset overrides the bypass so a stray do_update during reset is never visible.
  always_comb begin
    counter = tbl_q[pidx];
    if (!reset) begin
      counter = WEAK;
    end else if (upd && (last_pidx_q == pidx)) begin
      counter = train_cnt;
    end
  end

  assign taken = counter[CWIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= WEAK;
      end
      last_pidx_q <= '0;
      last_pred_q <= 1'b0;
    end else if (en) begin
      if (do_update) begin
        tbl_q[last_pidx_q] <= train_cnt;
      end
      last_pidx_q <= pidx;
      last_pred_q <= taken;
    end
  end

  sat_stat_counter #(
    .SWIDTH(SWIDTH)
  ) u_update_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (upd),
    .count(update_cnt)
  );

  sat_stat_counter #(
    .SWIDTH(SWIDTH)
  ) u_mispred_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (mispred),
    .count(mispred_cnt)
  );

endmodule

// File: tb/tb_pattern_history_table.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor drains and compares.
module tb_pattern_history_table;

  localparam int unsigned IW  = 6;
  localparam int unsigned HW  = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned SW  = 32;
  localparam int unsigned SW3 = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          do_update;
  logic          last_taken;
  logic [IW-1:0] index;
  logic [HW-1:0] history;

  logic           taken, taken3;
  logic [CW-1:0]  counter, counter3;
  logic [SW-1:0]  update_cnt, mispred_cnt;
  logic [SW3-1:0] update_cnt3, mispred_cnt3;

  always #5 clk = ~clk;

  pattern_history_table #(
    .IWIDTH(IW), .HWIDTH(HW), .CWIDTH(CW), .SWIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .do_update(do_update), .last_taken(last_taken),
    .index(index), .history(history), .taken(taken), .counter(counter),
    .update_cnt(update_cnt), .mispred_cnt(mispred_cnt)
  );

  // Narrow statistics instance to exercise clamping.
  pattern_history_table #(
    .IWIDTH(IW), .HWIDTH(HW), .CWIDTH(CW), .SWIDTH(SW3)
  ) dut3 (
    .clk(clk), .reset(reset), .en(en), .do_update(do_update), .last_taken(last_taken),
    .index(index), .history(history), .taken(taken3), .counter(counter3),
    .update_cnt(update_cnt3), .mispred_cnt(mispred_cnt3)
  );

  typedef struct {
    string       name;
    logic [1:0]  cnt;
    int unsigned upd;
    int unsigned mis;
    int unsigned upd3;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(string nm, int unsigned act, int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  // Monitor: outputs are compared mid-cycle, or immediately on an explicit sample event.
  always begin
    @(negedge clk or sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, " counter"}, 32'(counter), 32'(e.cnt));
      chk({e.name, " taken"}, 32'(taken), 32'(e.cnt[1]));
      chk({e.name, " update_cnt"}, update_cnt, e.upd);
      chk({e.name, " mispred_cnt"}, mispred_cnt, e.mis);
      chk({e.name, " counter(sw3)"}, 32'(counter3), 32'(e.cnt));
      chk({e.name, " update_cnt(sw3)"}, 32'(update_cnt3), e.upd3);
      chk({e.name, " mispred_cnt(sw3)"}, 32'(mispred_cnt3), e.mis);
    end
  end

  task automatic cyc(logic rst_v, logic e, logic du, logic lt, logic [IW-1:0] i,
                     logic [HW-1:0] h);
    @(posedge clk);
    #1;
    reset      = rst_v;
    en         = e;
    do_update  = du;
    last_taken = lt;
    index      = i;
    history    = h;
  endtask

  task automatic expect_now(string nm, logic [1:0] c, int unsigned u, int unsigned m,
                            int unsigned u3);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.upd  = u;
    e.mis  = m;
    e.upd3 = u3;
    q.push_back(e);
  endtask

  logic        lt_seq  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  cnt_seq [10] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00,
                                2'b00};
  int unsigned mis_seq [10] = '{0, 1, 1, 1, 2, 3, 3, 4, 4, 4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; do_update = 1'b0; last_taken = 1'b0; index = '0; history = '0;
    #1 reset = 1'b0;

    // Reset held: every lookup reads weakly-not-taken, even with a bypass-shaped update.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 4'd0);   expect_now("rst pidx0", 2'b01, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 4'd0);   expect_now("rst bypass", 2'b01, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'd63, 4'd15); expect_now("rst pidxmax", 2'b01, 0, 0, 0);

    // Training ramp on X = {5, 1010}; first update cycle also checks bypass.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 4'b1010); expect_now("lookup X", 2'b01, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1010); expect_now("ramp1 bypass", 2'b10, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1010); expect_now("ramp2", 2'b11, 1, 1, 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1010); expect_now("ramp3 sat", 2'b11, 2, 1, 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 4'b1010); expect_now("ramp done", 2'b11, 3, 1, 3);

    // Stall: held update must not train or count.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 4'b1010); expect_now("stall", 2'b11, 3, 1, 3);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 6'd5, 4'b1010); expect_now("stall release", 2'b10, 3, 1, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 4'b1011); expect_now("other entry", 2'b01, 4, 2, 4);

    // Pending update to {5,1011} is dropped by an async reset between edges.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1010); expect_now("pre async", 2'b10, 4, 2, 4);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 expect_now("async reset", 2'b01, 0, 0, 0);
    -> sample_ev;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1011); expect_now("dropped upd", 2'b01, 0, 0, 0);
    // That update had no prior lookup since reset, so it trained entry 0.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 4'd0);    expect_now("entry0 trained", 2'b10, 1, 1, 1);

    // Statistics: 10 updates on {9,0011}, 4 mispredicts, narrow counter clamps at 7.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 4'd0);    expect_now("rst again", 2'b01, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd9, 4'd3);    expect_now("stats lookup", 2'b01, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 1'b1, lt_seq[k], 6'd9, 4'd3);
      expect_now($sformatf("stats u%0d", k + 1), cnt_seq[k], k, mis_seq[k],
                 (k > 7) ? 7 : k);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd9, 4'd3);    expect_now("stats final", 2'b00, 10, 4, 7);

    @(negedge clk);
    #1 chk("queue drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
